// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM power-up sequence checker.
//
// Contents:
//   sdram_cmd_e   : {cs_n,ras_n,cas_n,we_n} command encodings
//   init_state_e  : states of the initialisation checker FSM
//   E_*           : error codes reported on err_code (first violation wins)
//   *_LSB/*_MSB   : bit positions of the mode register fields on A11..A0
//   is_nop()      : true for NOP and for any deselected (cs_n = 1) cycle
// ---------------------------------------------------------------------------
package sdram_pkg;

   // Command encodings as seen on {cs_n,ras_n,cas_n,we_n}.
   typedef enum logic [3:0] {
      CMD_MSET = 4'b0000,
      CMD_AREF = 4'b0001,
      CMD_PRE  = 4'b0010,
      CMD_ACT  = 4'b0011,
      CMD_WR   = 4'b0100,
      CMD_RD   = 4'b0101,
      CMD_BST  = 4'b0110,
      CMD_NOP  = 4'b0111
   } sdram_cmd_e;

   // Checker FSM states. S_DONE and S_ERR are terminal until reset.
   typedef enum logic [2:0] {
      S_WAIT,
      S_PRE,
      S_AREF1,
      S_AREFN,
      S_MRD,
      S_DONE,
      S_ERR
   } init_state_e;

   // Error codes. Zero means no error has been seen.
   localparam logic [2:0] E_NONE    = 3'd0;
   localparam logic [2:0] E_EARLY   = 3'd1;
   localparam logic [2:0] E_ORDER   = 3'd2;
   localparam logic [2:0] E_PRE_A10 = 3'd3;
   localparam logic [2:0] E_TRP     = 3'd4;
   localparam logic [2:0] E_TRC     = 3'd5;
   localparam logic [2:0] E_MODE    = 3'd6;
   localparam logic [2:0] E_TMRD    = 3'd7;

   // Mode register field positions on the address bus.
   localparam int BL_LSB  = 0;
   localparam int BL_MSB  = 2;
   localparam int BT_BIT  = 3;
   localparam int CL_LSB  = 4;
   localparam int CL_MSB  = 6;
   localparam int OPM_LSB = 7;
   localparam int OPM_MSB = 8;
   localparam int WB_BIT  = 9;

   // A10 selects "precharge all banks" on a PRECHARGE command.
   localparam int A10_BIT = 10;

   // A deselected device (cs_n = 1) ignores the other command pins, so any
   // such cycle behaves exactly like a NOP.
   function automatic logic is_nop(input logic [3:0] cmd);
      return cmd[3] || (cmd == CMD_NOP);
   endfunction

endpackage

// File: rtl/sdram_mode_decode.sv
// ---------------------------------------------------------------------------
// sdram_mode_decode
// Purely combinational split of the MODE REGISTER SET address into its
// fields, plus a flag for encodings the checker refuses to accept.
//
// Ports:
//   mode_addr        in  10  A9..A0 sampled with the MSET command
//   burst_len        out  3  A2..A0
//   burst_type       out  1  A3 (0 = sequential, 1 = interleaved)
//   cas_lat          out  3  A6..A4
//   wr_burst_single  out  1  A9 (1 = single-location writes)
//   reserved         out  1  field combination is reserved / unsupported
// ---------------------------------------------------------------------------
module sdram_mode_decode
   import sdram_pkg::*;
(
   input  logic [9:0] mode_addr,
   output logic [2:0] burst_len,
   output logic       burst_type,
   output logic [2:0] cas_lat,
   output logic       wr_burst_single,
   output logic       reserved
);

   logic [1:0] op_mode;

   // Slice the address into fields, then flag anything we do not support:
   // a non-standard operating mode, a CAS latency other than 2 or 3, the
   // undefined burst lengths 4..6, and full-page bursts in interleaved
   // order (full page only exists for sequential bursts).
   always_comb begin
      burst_len       = mode_addr[BL_MSB:BL_LSB];
      burst_type      = mode_addr[BT_BIT];
      cas_lat         = mode_addr[CL_MSB:CL_LSB];
      op_mode         = mode_addr[OPM_MSB:OPM_LSB];
      wr_burst_single = mode_addr[WB_BIT];
      reserved        = 1'b0;

      if (op_mode != 2'b00) begin
         reserved = 1'b1;
      end
      if ((cas_lat != 3'd2) && (cas_lat != 3'd3)) begin
         reserved = 1'b1;
      end
      if ((burst_len == 3'd4) || (burst_len == 3'd5) || (burst_len == 3'd6)) begin
         reserved = 1'b1;
      end
      if ((burst_len == 3'd7) && burst_type) begin
         reserved = 1'b1;
      end
   end

endmodule

// File: rtl/sdram_init_checker.sv
// ---------------------------------------------------------------------------
// sdram_init_checker
// Passive monitor of the SDRAM command/address bus. Follows the power-up
// sequence (long idle, PRECHARGE-all, two or more AUTO REFRESH, MODE
// REGISTER SET) and its minimum command spacing, captures the programmed
// mode register, and latches either a sticky "done" or the first error.
// It never drives the SDRAM bus.
//
// Parameters:
//   DELAY_200US  idle cycles required after reset before the first command
//   T_RP         minimum PRECHARGE -> next command spacing (cycles)
//   T_RC         minimum AUTO REFRESH -> next command spacing (cycles)
//   T_MRD        MODE REGISTER SET -> next command spacing, and done delay
//
// Ports:
//   sclk             in   1  system clock
//   rst              in   1  asynchronous active-high reset
//   sdram_cmd        in   4  {cs_n,ras_n,cas_n,we_n}
//   sdram_addr       in  12  A11..A0
//   mode_valid       out  1  mode fields below come from a legal MSET
//   burst_len        out  3  captured A2..A0
//   burst_type       out  1  captured A3
//   cas_lat          out  3  captured A6..A4
//   wr_burst_single  out  1  captured A9
//   chk_done         out  1  sequence completed legally (sticky)
//   chk_err          out  1  violation detected (sticky)
//   err_code         out  3  code of the first violation
// ---------------------------------------------------------------------------
module sdram_init_checker
   import sdram_pkg::*;
#(
   parameter int DELAY_200US = 20000,
   parameter int T_RP        = 2,
   parameter int T_RC        = 8,
   parameter int T_MRD       = 2
)
(
   input  logic        sclk,
   input  logic        rst,
   input  logic [3:0]  sdram_cmd,
   input  logic [11:0] sdram_addr,
   output logic        mode_valid,
   output logic [2:0]  burst_len,
   output logic        burst_type,
   output logic [2:0]  cas_lat,
   output logic        wr_burst_single,
   output logic        chk_done,
   output logic        chk_err,
   output logic [2:0]  err_code
);

   localparam logic [14:0] DELAY_C = 15'(DELAY_200US);
   localparam logic [3:0]  T_RP_C  = 4'(T_RP);
   localparam logic [3:0]  T_RC_C  = 4'(T_RC);
   localparam logic [3:0]  T_MRD_C = 4'(T_MRD);

   init_state_e state;
   init_state_e state_next;

   logic [14:0] idle_cnt;
   logic [3:0]  gap_cnt;

   logic        cmd_nop;
   logic        cmd_pre;
   logic        cmd_aref;
   logic        cmd_mset;
   logic        a10;

   logic        accept;
   logic        err_set;
   logic [2:0]  err_next;
   logic        mode_load;
   logic        done_set;

   logic [2:0]  dec_burst_len;
   logic        dec_burst_type;
   logic [2:0]  dec_cas_lat;
   logic        dec_wr_burst_single;
   logic        dec_reserved;

   // A11 carries no meaning for any command this checker looks at.
   logic        unused_addr_bits;
   assign unused_addr_bits = sdram_addr[11];

   assign cmd_nop  = is_nop(sdram_cmd);
   assign cmd_pre  = (sdram_cmd == CMD_PRE);
   assign cmd_aref = (sdram_cmd == CMD_AREF);
   assign cmd_mset = (sdram_cmd == CMD_MSET);
   assign a10      = sdram_addr[A10_BIT];

   sdram_mode_decode u_mode_decode (
      .mode_addr       (sdram_addr[9:0]),
      .burst_len       (dec_burst_len),
      .burst_type      (dec_burst_type),
      .cas_lat         (dec_cas_lat),
      .wr_burst_single (dec_wr_burst_single),
      .reserved        (dec_reserved)
   );

   // Next-state and event logic. Each state only reacts to non-NOP
   // commands (except S_MRD, which also times out into S_DONE). Within a
   // state the checks are ordered so that when one command breaks several
   // rules the most fundamental one is reported: too-early before a bad
   // A10, spacing before wrong command, wrong command before bad mode.
   // Any error overrides the computed next state and sends us to S_ERR.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      err_set    = 1'b0;
      err_next   = E_NONE;
      mode_load  = 1'b0;
      done_set   = 1'b0;

      case (state)
         S_WAIT: begin
            if (!cmd_nop) begin
               if (idle_cnt < DELAY_C) begin
                  err_set  = 1'b1;
                  err_next = E_EARLY;
               end else if (cmd_pre) begin
                  if (a10) begin
                     state_next = S_PRE;
                     accept     = 1'b1;
                  end else begin
                     err_set  = 1'b1;
                     err_next = E_PRE_A10;
                  end
               end else begin
                  err_set  = 1'b1;
                  err_next = E_ORDER;
               end
            end
         end

         S_PRE: begin
            if (!cmd_nop) begin
               if (gap_cnt < T_RP_C) begin
                  err_set  = 1'b1;
                  err_next = E_TRP;
               end else if (cmd_aref) begin
                  state_next = S_AREF1;
                  accept     = 1'b1;
               end else begin
                  err_set  = 1'b1;
                  err_next = E_ORDER;
               end
            end
         end

         S_AREF1: begin
            if (!cmd_nop) begin
               if (gap_cnt < T_RC_C) begin
                  err_set  = 1'b1;
                  err_next = E_TRC;
               end else if (cmd_aref) begin
                  state_next = S_AREFN;
                  accept     = 1'b1;
               end else begin
                  err_set  = 1'b1;
                  err_next = E_ORDER;
               end
            end
         end

         S_AREFN: begin
            if (!cmd_nop) begin
               if (gap_cnt < T_RC_C) begin
                  err_set  = 1'b1;
                  err_next = E_TRC;
               end else if (cmd_aref) begin
                  accept = 1'b1;
               end else if (cmd_mset) begin
                  if (dec_reserved) begin
                     err_set  = 1'b1;
                     err_next = E_MODE;
                  end else begin
                     state_next = S_MRD;
                     accept     = 1'b1;
                     mode_load  = 1'b1;
                  end
               end else begin
                  err_set  = 1'b1;
                  err_next = E_ORDER;
               end
            end
         end

         S_MRD: begin
            if (gap_cnt >= T_MRD_C) begin
               state_next = S_DONE;
               done_set   = 1'b1;
            end else if (!cmd_nop) begin
               err_set  = 1'b1;
               err_next = E_TMRD;
            end
         end

         default: begin
         end
      endcase

      if (err_set) begin
         state_next = S_ERR;
      end
   end

   // State register.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state <= S_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // Idle counter: counts every cycle spent in S_WAIT and saturates, so a
   // very long power-up idle can never wrap back below the threshold.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if ((state == S_WAIT) && (idle_cnt != '1)) begin
         idle_cnt <= idle_cnt + 15'd1;
      end
   end

   // Gap counter: reloaded with 1 after each accepted command so that, when
   // the next command arrives, it holds exactly the issue-cycle distance.
   // Saturation at 15 keeps long gaps "long enough" for every check.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (accept) begin
         gap_cnt <= 4'd1;
      end else if (gap_cnt != 4'hF) begin
         gap_cnt <= gap_cnt + 4'd1;
      end
   end

   // Registered results. The mode fields are captured only from an MSET
   // that was accepted, so mode_valid always describes legal fields. The
   // done/error flags and the error code are set once on entry to the
   // terminal state; since both terminal states are absorbing, the first
   // violation is the one that remains visible.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         mode_valid      <= 1'b0;
         burst_len       <= '0;
         burst_type      <= 1'b0;
         cas_lat         <= '0;
         wr_burst_single <= 1'b0;
         chk_done        <= 1'b0;
         chk_err         <= 1'b0;
         err_code        <= E_NONE;
      end else begin
         if (mode_load) begin
            mode_valid      <= 1'b1;
            burst_len       <= dec_burst_len;
            burst_type      <= dec_burst_type;
            cas_lat         <= dec_cas_lat;
            wr_burst_single <= dec_wr_burst_single;
         end
         if (done_set) begin
            chk_done <= 1'b1;
         end
         if (err_set) begin
            chk_err  <= 1'b1;
            err_code <= err_next;
         end
      end
   end

endmodule

// File: tb/tb_sdram_init_checker.sv
// ---------------------------------------------------------------------------
// tb_sdram_init_checker
// Directed bench for sdram_init_checker. Two instances share the bus: the
// main one with T_RP = 2 and a second with T_RP = 3 so the precharge spacing
// can be exercised at both sides of its limit. The idle delay is shortened
// to keep run time small; all expected values are written out by hand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_init_checker;

   localparam int DELAY = 300;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] PRE  = 4'b0010;
   localparam logic [3:0] AREF = 4'b0001;
   localparam logic [3:0] MSET = 4'b0000;
   localparam logic [3:0] ACT  = 4'b0011;

   logic        sclk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  sdram_cmd = NOP;
   logic [11:0] sdram_addr = '0;

   logic        mode_valid, burst_type, wr_burst_single, chk_done, chk_err;
   logic [2:0]  burst_len, cas_lat, err_code;

   logic        mode_valid_b, burst_type_b, wr_burst_single_b, chk_done_b, chk_err_b;
   logic [2:0]  burst_len_b, cas_lat_b, err_code_b;

   int check_count = 0;
   int pass_count  = 0;

   always #5 sclk = ~sclk;

   sdram_init_checker #(.DELAY_200US(DELAY), .T_RP(2), .T_RC(8), .T_MRD(2)) dut (
      .sclk(sclk), .rst(rst), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
      .mode_valid(mode_valid), .burst_len(burst_len), .burst_type(burst_type),
      .cas_lat(cas_lat), .wr_burst_single(wr_burst_single),
      .chk_done(chk_done), .chk_err(chk_err), .err_code(err_code)
   );

   sdram_init_checker #(.DELAY_200US(DELAY), .T_RP(3), .T_RC(8), .T_MRD(2)) dut_rp3 (
      .sclk(sclk), .rst(rst), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
      .mode_valid(mode_valid_b), .burst_len(burst_len_b), .burst_type(burst_type_b),
      .cas_lat(cas_lat_b), .wr_burst_single(wr_burst_single_b),
      .chk_done(chk_done_b), .chk_err(chk_err_b), .err_code(err_code_b)
   );

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one command at the falling edge; the DUT samples it on the next rise.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [11:0] addr);
      @(negedge sclk);
      sdram_cmd  = cmd;
      sdram_addr = addr;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(NOP, 12'h000);
      end
   endtask

   // Issue a command exactly 'gap' cycles after the previous one.
   task automatic gapCmd(input int gap, input logic [3:0] cmd, input logic [11:0] addr);
      nops(gap - 1);
      applyStimulus(cmd, addr);
   endtask

   task automatic doReset(input string tag);
      @(negedge sclk);
      rst        = 1'b1;
      sdram_cmd  = NOP;
      sdram_addr = 12'h000;
      @(negedge sclk);
      checkOutput({tag, " rst chk_done"},   32'(chk_done),   32'd0);
      checkOutput({tag, " rst chk_err"},    32'(chk_err),    32'd0);
      checkOutput({tag, " rst err_code"},   32'(err_code),   32'd0);
      checkOutput({tag, " rst mode_valid"}, 32'(mode_valid), 32'd0);
      checkOutput({tag, " rst burst_len"},  32'(burst_len),  32'd0);
      checkOutput({tag, " rst cas_lat"},    32'(cas_lat),    32'd0);
      checkOutput({tag, " rst b chk_err"},  32'(chk_err_b),  32'd0);
      rst = 1'b0;
   endtask

   task automatic expectError(input string tag, input int code);
      checkOutput({tag, " chk_err"},  32'(chk_err),  32'd1);
      checkOutput({tag, " err_code"}, 32'(err_code), 32'(code));
      checkOutput({tag, " chk_done"}, 32'(chk_done), 32'd0);
   endtask

   task automatic expectDone(input string tag, input logic done);
      checkOutput({tag, " chk_done"}, 32'(chk_done), 32'(done));
      checkOutput({tag, " chk_err"},  32'(chk_err),  32'd0);
      checkOutput({tag, " err_code"}, 32'(err_code), 32'd0);
   endtask

   task automatic expectMode(input string tag, input logic [2:0] bl, input logic bt,
                             input logic [2:0] cl, input logic wb);
      checkOutput({tag, " mode_valid"}, 32'(mode_valid),      32'd1);
      checkOutput({tag, " burst_len"},  32'(burst_len),       32'(bl));
      checkOutput({tag, " burst_type"}, 32'(burst_type),      32'(bt));
      checkOutput({tag, " cas_lat"},    32'(cas_lat),         32'(cl));
      checkOutput({tag, " wr_single"},  32'(wr_burst_single), 32'(wb));
   endtask

   // Reset, idle exactly DELAY cycles, PRE-all, first AREF at +2.
   task automatic toAref1(input string tag);
      doReset(tag);
      nops(DELAY - 1);
      applyStimulus(PRE, 12'h400);
      gapCmd(2, AREF, 12'h000);
   endtask

   task automatic toArefn(input string tag);
      toAref1(tag);
      gapCmd(8, AREF, 12'h000);
   endtask

   // Cases from S_AREF1: gap, command, expected error.
   int         a1_gap  [4] = '{5, 7, 8, 3};
   logic [3:0] a1_cmd  [4] = '{AREF, AREF, MSET, MSET};
   int         a1_code [4] = '{5, 5, 2, 5};

   // Cases from S_AREFN: gap, command, address, expected error.
   int          an_gap  [6] = '{8, 7, 8, 8, 8, 8};
   logic [3:0]  an_cmd  [6] = '{PRE, MSET, MSET, MSET, MSET, MSET};
   logic [11:0] an_addr [6] = '{12'h400, 12'h032, 12'h052, 12'h036, 12'h03F, 12'h0B2};
   int          an_code [6] = '{2, 5, 6, 6, 6, 6};

   // Legal MSET variants: address and the fields it must decode to.
   logic [11:0] lg_addr [3] = '{12'h232, 12'h037, 12'h02B};
   logic [2:0]  lg_bl   [3] = '{3'd2, 3'd7, 3'd3};
   logic        lg_bt   [3] = '{1'b0, 1'b0, 1'b1};
   logic [2:0]  lg_cl   [3] = '{3'd3, 3'd3, 3'd2};
   logic        lg_wb   [3] = '{1'b1, 1'b0, 1'b0};

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Legal sequence with the idle count exactly at its threshold.
      doReset("legal");
      nops(DELAY - 1);
      applyStimulus(PRE, 12'h400);
      nops(1);
      expectDone("legal pre", 1'b0);
      gapCmd(1, AREF, 12'h000);
      nops(1);
      expectDone("legal aref1", 1'b0);
      checkOutput("trp3 gap2 chk_err", 32'(chk_err_b), 32'd1);
      checkOutput("trp3 gap2 err_code", 32'(err_code_b), 32'd4);
      gapCmd(7, AREF, 12'h000);
      gapCmd(8, MSET, 12'h032);
      nops(1);
      expectMode("legal mset", 3'd2, 1'b0, 3'd3, 1'b0);
      expectDone("legal mrd1", 1'b0);
      nops(1);
      expectDone("legal mrd2", 1'b0);
      nops(1);
      expectDone("legal done", 1'b1);
      applyStimulus(ACT, 12'h000);
      applyStimulus(PRE, 12'h000);
      nops(1);
      expectDone("after done", 1'b1);
      expectMode("after done", 3'd2, 1'b0, 3'd3, 1'b0);

      // Too-early commands (also checks early beats bad A10).
      doReset("early100");
      nops(99);
      applyStimulus(PRE, 12'h000);
      nops(1);
      expectError("early100", 1);
      nops(3);
      expectError("early100 held", 1);

      doReset("early edge");
      nops(DELAY - 2);
      applyStimulus(PRE, 12'h400);
      nops(1);
      expectError("early edge", 1);

      doReset("pre a10");
      nops(DELAY);
      applyStimulus(PRE, 12'h000);
      nops(1);
      expectError("pre a10", 3);

      doReset("wait order");
      nops(DELAY);
      applyStimulus(AREF, 12'h000);
      nops(1);
      expectError("wait order", 2);

      // Precharge spacing on both instances.
      doReset("trp1");
      nops(DELAY);
      applyStimulus(PRE, 12'h400);
      gapCmd(1, AREF, 12'h000);
      nops(1);
      expectError("trp1", 4);

      doReset("trp3 ok");
      nops(DELAY);
      applyStimulus(PRE, 12'h400);
      gapCmd(3, AREF, 12'h000);
      nops(1);
      checkOutput("trp3 gap3 chk_err", 32'(chk_err_b), 32'd0);
      expectDone("trp3 gap3 main", 1'b0);

      doReset("pre order");
      nops(DELAY);
      applyStimulus(PRE, 12'h400);
      gapCmd(2, ACT, 12'h000);
      nops(1);
      expectError("pre order", 2);

      for (int i = 0; i < 4; i++) begin
         toAref1("aref1 case");
         gapCmd(a1_gap[i], a1_cmd[i], 12'h032);
         nops(1);
         expectError($sformatf("aref1 case%0d", i), a1_code[i]);
      end

      for (int i = 0; i < 6; i++) begin
         toArefn("arefn case");
         gapCmd(an_gap[i], an_cmd[i], an_addr[i]);
         nops(1);
         expectError($sformatf("arefn case%0d", i), an_code[i]);
         checkOutput($sformatf("arefn case%0d mode_valid", i), 32'(mode_valid), 32'd0);
      end

      for (int i = 0; i < 3; i++) begin
         toArefn("mode legal");
         gapCmd(8, MSET, lg_addr[i]);
         nops(3);
         expectDone($sformatf("mode legal%0d", i), 1'b1);
         expectMode($sformatf("mode legal%0d", i), lg_bl[i], lg_bt[i], lg_cl[i], lg_wb[i]);
      end

      // Command too soon after MSET; mode fields stay valid.
      toArefn("tmrd");
      gapCmd(8, MSET, 12'h032);
      applyStimulus(ACT, 12'h000);
      nops(1);
      expectError("tmrd", 7);
      expectMode("tmrd", 3'd2, 1'b0, 3'd3, 1'b0);

      // Extra refreshes are allowed.
      toArefn("four aref");
      gapCmd(8, AREF, 12'h000);
      gapCmd(8, AREF, 12'h000);
      gapCmd(8, MSET, 12'h032);
      nops(3);
      expectDone("four aref", 1'b1);

      // Reset in S_AREF1, then a full legal run.
      toAref1("mid rst");
      nops(2);
      doReset("mid rst");
      nops(DELAY - 1);
      applyStimulus(PRE, 12'h400);
      gapCmd(2, AREF, 12'h000);
      gapCmd(8, AREF, 12'h000);
      gapCmd(8, MSET, 12'h032);
      nops(3);
      expectDone("mid rst done", 1'b1);

      // Reset must also clear the idle counter.
      doReset("idle restart");
      nops(DELAY);
      doReset("idle restart");
      nops(99);
      applyStimulus(PRE, 12'h400);
      nops(1);
      expectError("idle restart", 1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
